// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: glyph patterns, segment indices and the
// readback FSM states. The display writer path uses the same glyph constants.
package sseg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high patterns, bit order {dp, g, f, e, d, c, b, a}.
  localparam logic [7:0] SSEG_0 = 8'h3F;
  localparam logic [7:0] SSEG_1 = 8'h06;
  localparam logic [7:0] SSEG_2 = 8'h5B;
  localparam logic [7:0] SSEG_3 = 8'h4F;
  localparam logic [7:0] SSEG_4 = 8'h66;
  localparam logic [7:0] SSEG_5 = 8'h6D;
  localparam logic [7:0] SSEG_6 = 8'h7D;
  localparam logic [7:0] SSEG_7 = 8'h07;
  localparam logic [7:0] SSEG_8 = 8'h7F;
  localparam logic [7:0] SSEG_9 = 8'h6F;
  localparam logic [7:0] SSEG_A = 8'h77;
  localparam logic [7:0] SSEG_B = 8'h7C;
  localparam logic [7:0] SSEG_C = 8'h39;
  localparam logic [7:0] SSEG_D = 8'h5E;
  localparam logic [7:0] SSEG_E = 8'h79;
  localparam logic [7:0] SSEG_F = 8'h71;

  localparam logic [7:0] SSEG_TABLE [16] = '{
    SSEG_0, SSEG_1, SSEG_2, SSEG_3, SSEG_4, SSEG_5, SSEG_6, SSEG_7,
    SSEG_8, SSEG_9, SSEG_A, SSEG_B, SSEG_C, SSEG_D, SSEG_E, SSEG_F
  };

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } state_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational reverse lookup of a segment pattern (dp excluded) to its hex
// nibble, with a legality flag for patterns that are not hex glyphs.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] segs,
  output logic       legal,
  output logic [3:0] nibble
);

  // NOTE: every output gets a default before the search loop so no path
  // through this block leaves a value held, which would infer a latch.
  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (segs == SSEG_TABLE[i][6:0]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sseg_readback.sv
// Passive monitor for a multiplexed seven-segment bus: captures each digit's
// nibble and decimal point once its {anode, cathode} pair has been stable.
module sseg_readback
  import sseg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     anode,
  input  logic [7:0]            cathode,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  illegal,
  output logic                  frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [DIGITS-1:0] s_anode, p_anode;
  logic [7:0]        s_cath, p_cath;
  logic [DIGITS-1:0] seen;
  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              capture;
  logic              sel_ok, same;
  logic              legal;
  logic [3:0]        nibble;

  sseg_pattern_decode u_decode (
    .segs   (s_cath[6:0]),
    .legal  (legal),
    .nibble (nibble)
  );

  assign sel_ok = $onehot(~s_anode);
  assign same   = ({s_anode, s_cath} == {p_anode, p_cath});

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_ok) begin
          state_nx = TRACK;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx   = '0;
        end
      end
      TRACK: begin
        if (!sel_ok) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (!same) begin
          cnt_nx   = CW'(1);
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          // This edge is the STABLE_CYCLES-th consecutive identical sample.
          capture  = 1'b1;
          state_nx = HELD;
          cnt_nx   = CW'(STABLE_CYCLES);
        end else begin
          cnt_nx   = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!sel_ok) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (!same) begin
          state_nx = TRACK;
          cnt_nx   = CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_anode     <= '0;
      p_anode     <= '0;
      s_cath      <= '0;
      p_cath      <= '0;
      state       <= IDLE;
      cnt         <= '0;
      seen        <= '0;
      value       <= '0;
      dp          <= '0;
      digit_valid <= '0;
      illegal     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      s_anode    <= anode;
      s_cath     <= cathode;
      p_anode    <= s_anode;
      p_cath     <= s_cath;
      state      <= state_nx;
      cnt        <= cnt_nx;
      illegal    <= capture && !legal;
      frame_done <= &seen;
      // A completed frame clears the mask in the same cycle frame_done rises.
      seen       <= ((&seen) ? '0 : seen) | (capture ? ~s_anode : '0);
      if (capture) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (!s_anode[i]) begin
            dp[i]          <= s_cath[SEG_DP];
            digit_valid[i] <= legal;
            if (legal) value[4*i +: 4] <= nibble;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_readback.sv
// Self-checking bench: a run-length reference model of the display bus drives
// per-cycle comparison, plus directed scenarios with literal expectations.
module tb_sseg_readback;

  localparam int D = 4;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [D-1:0]  anode;
  logic [7:0]    cathode;
  logic [4*D-1:0] value;
  logic [D-1:0]  dp;
  logic [D-1:0]  digit_valid;
  logic          illegal;
  logic          frame_done;

  sseg_readback #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .anode       (anode),
    .cathode     (cathode),
    .value       (value),
    .dp          (dp),
    .digit_valid (digit_valid),
    .illegal     (illegal),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: a digit is captured when its sampled pair has been seen
  // on exactly S consecutive edges; the decision lands one edge later.
  logic [4*D-1:0] m_val;
  logic [D-1:0]   m_dp, m_vld, m_seen;
  logic           m_ill, m_fd;
  logic [D+7:0]   m_pair;
  int             m_run;

  always @(posedge clk) begin
    if (reset) begin
      m_val = '0; m_dp = '0; m_vld = '0; m_seen = '0;
      m_ill = 1'b0; m_fd = 1'b0; m_pair = '0; m_run = 0;
    end else begin
      int zeros, idx, nib;
      bit ok;
      m_fd = (m_seen == '1);
      if (m_fd) m_seen = '0;
      m_ill = 1'b0;
      zeros = 0; idx = 0;
      for (int i = 0; i < D; i++)
        if (!m_pair[8+i]) begin zeros++; idx = i; end
      if (zeros == 1 && m_run == S) begin
        ok = 0; nib = 0;
        for (int g = 0; g < 16; g++)
          if (glyphs[g] == m_pair[6:0]) begin ok = 1; nib = g; end
        m_dp[idx]   = m_pair[7];
        m_vld[idx]  = ok;
        m_seen[idx] = 1'b1;
        if (ok) m_val[4*idx +: 4] = 4'(nib);
        else    m_ill = 1'b1;
      end
      if ({anode, cathode} == m_pair) begin
        if (m_run <= S) m_run++;
      end else begin
        m_run = 1;
      end
      m_pair = {anode, cathode};
    end
  end

  int n_ill = 0;
  int n_fd  = 0;

  always @(negedge clk) begin
    check("value",       32'(value),       32'(m_val));
    check("dp",          32'(dp),          32'(m_dp));
    check("digit_valid", 32'(digit_valid), 32'(m_vld));
    check("illegal",     32'(illegal),     32'(m_ill));
    check("frame_done",  32'(frame_done),  32'(m_fd));
    if (illegal)    n_ill++;
    if (frame_done) n_fd++;
  end

  task automatic hold(input logic [D-1:0] an, input logic [7:0] ca, input int n);
    anode   = an;
    cathode = ca;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base_ill, base_fd;
    reset   = 1'b1;
    anode   = '1;
    cathode = '0;
    repeat (3) @(negedge clk);
    check("reset_value", 32'(value), 32'h0);
    check("reset_flags", 32'({dp, digit_valid, illegal, frame_done}), 32'h0);
    reset = 1'b0;

    base_ill = n_ill;
    hold(4'b1110, 8'h7D, 4);
    hold(4'b1111, 8'h00, 2);
    check("t1_nibble", 32'(value[3:0]), 32'h6);
    check("t1_dp",     32'(dp[0]),      32'h0);
    check("t1_valid",  32'(digit_valid), 32'b0001);
    check("t1_illegal_count", 32'(n_ill - base_ill), 32'd0);

    hold(4'b1101, 8'hFF, 14);
    hold(4'b1111, 8'h00, 2);
    check("t2_nibble", 32'(value[7:4]), 32'h8);
    check("t2_dp",     32'(dp[1]),      32'h1);

    base_ill = n_ill;
    hold(4'b1011, 8'h01, 4);
    hold(4'b1111, 8'h00, 2);
    check("t3_illegal_count", 32'(n_ill - base_ill), 32'd1);
    check("t3_valid",  32'(digit_valid), 32'b0011);
    check("t3_nibble", 32'(value[11:8]), 32'h0);

    hold(4'b0111, 8'h71, 3);
    hold(4'b1111, 8'h00, 3);
    check("t4_nibble", 32'(value[15:12]), 32'h0);
    check("t4_valid",  32'(digit_valid[3]), 32'h0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base_fd = n_fd;
    hold(4'b1110, 8'h06, 6);
    hold(4'b1101, 8'h5B, 6);
    hold(4'b1011, 8'h4F, 6);
    hold(4'b0111, 8'h66, 6);
    hold(4'b1111, 8'h00, 3);
    check("t5_value", 32'(value), 32'h4321);
    check("t5_valid", 32'(digit_valid), 32'b1111);
    check("t5_frame_count", 32'(n_fd - base_fd), 32'd1);

    hold(4'b1110, 8'h3F, 2);
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_value", 32'(value), 32'h0);
    check("t6_reset_valid", 32'(digit_valid), 32'h0);
    reset = 1'b0;
    hold(4'b1110, 8'h3F, 4);
    hold(4'b1111, 8'h00, 2);
    check("t6_recapture_valid", 32'(digit_valid), 32'b0001);
    check("t6_recapture_value", 32'(value), 32'h0);

    for (int k = 0; k < 400; k++) begin
      logic [D-1:0] an;
      logic [7:0]   ca;
      int           r;
      r = $urandom_range(0, 9);
      if (r < 7)       an = ~(D'(1) << $urandom_range(0, D - 1));
      else if (r == 7) an = '1;
      else             an = D'($urandom);
      if ($urandom_range(0, 3) != 0)
        ca = {1'($urandom), glyphs[$urandom_range(0, 15)]};
      else
        ca = 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      hold(an, ca, $urandom_range(1, 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sseg_readback.md
Name: sseg_readback

Overview:
- Passive monitor on the multiplexed seven-segment display bus (anode select plus cathode pattern).
- Reconstructs the hex nibble and decimal point shown on each digit.
- Flags patterns that are not legal hex glyphs.
- Used by self-checking display benches and by the on-chip display loopback check; it is the reader for the segment-pattern writer path.

Parameters:
- DIGITS, 4, number of multiplexed digits (anode width).
- STABLE_CYCLES, 4, consecutive identical samples required before a capture (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- anode  in  DIGITS  digit select, active-low; exactly one low bit means a valid select.
- cathode  in  8  segment pattern, active-high: [0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g, [7]=dp.
- value  out  4*DIGITS  captured nibbles; digit i occupies [4i+3:4i].
- dp  out  DIGITS  captured decimal point per digit.
- digit_valid  out  DIGITS  set when the digit's last capture was a legal glyph.
- illegal  out  1  one-cycle pulse on capture of a non-glyph pattern.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the previous pulse.

Behaviour:
- Reset: value=0, dp=0, digit_valid=0, illegal=0, frame_done=0. State IDLE, stability counter=0, seen-mask=0.
- Inputs are registered once on entry (sample stage). All decisions use the sampled {anode, cathode} pair and the previous sample.
- Glyph table, cathode[6:0] to nibble: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other value is illegal.
- IDLE:
  - Sampled anode not one-hot-low (all high, or more than one low): stay in IDLE, counter=0.
  - One-hot-low: go to TRACK, counter=1.
- TRACK:
  - Pair equal to previous sample: counter increments.
  - Pair differs and is still a valid select: counter=1, stay in TRACK.
  - Anode not a valid select: go to IDLE.
  - Counter reaches STABLE_CYCLES: capture and go to HELD.
- Capture timing: a pair applied before edge E0 and held is written on edge E(STABLE_CYCLES). Outputs are visible after that edge.
- Capture, legal glyph: value nibble[i] and dp[i] <= decoded values, digit_valid[i] <= 1, seen-mask[i] <= 1.
- Capture, illegal glyph: value nibble[i] unchanged, dp[i] <= cathode[7], digit_valid[i] <= 0, seen-mask[i] <= 1, illegal pulses for one cycle.
- HELD: no recapture while the pair is unchanged. On change, behave as TRACK/IDLE entry (counter=1, or go to IDLE).
- frame_done:
  - Pulses on the cycle after the capture that makes seen-mask all ones.
  - seen-mask clears in the same cycle.
  - digit_valid and value persist.
- A glitch shorter than STABLE_CYCLES causes no capture and no output change.
- Reset asserted mid-dwell forces the reset values on the next edge. Any partial count is discarded.
- The dp bit is included in the pair comparison: a change of dp alone restarts the count.

Decomposition:
- Shared package sseg_pkg:
  - Glyph constants SSEG_0..SSEG_F, active-high in the [7:0] order above.
  - Segment index constants.
  - State enum {IDLE, TRACK, HELD}.
  - The same constants serve the display writer path.
- Sub-module sseg_pattern_decode, combinational: cathode[6:0] to {legal, nibble[3:0]}, using the package table.

Test Plan:
- anode=1110, cathode=01111101 held 4 cycles -> value[3:0]=6, dp[0]=0, digit_valid=0001; illegal stays 0.
- anode=1101, cathode=11111111 held 4 cycles, then held 10 more -> value[7:4]=8, dp[1]=1; exactly one capture, no repeat.
- anode=1011, cathode=00000001 held 4 cycles -> illegal pulses once, digit_valid[2]=0, value[11:8] unchanged.
- anode=0111, cathode=0x71 for 3 cycles, then anode=1111 -> no capture, value[15:12]=0.
- Scan digits 0..3 with glyphs 1, 2, 3, 4 at 6 cycles each -> value=16'h4321, digit_valid=1111, frame_done pulses once after the digit-3 capture.
- reset at cycle 2 of a 4-cycle dwell on digit 0 (cathode=0x3F) -> all outputs 0 next edge; re-held 4 cycles after reset -> capture occurs.
